seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Parametrised multi-cycle restoring divider: WIDTH-bit dividend / WIDTH-bit divisor -> quotient, remainder.
//  Computes one quotient bit per clock, with a start/busy/done handshake.
//  Adds optional signed mode (truncate toward zero), divide-by-zero and overflow flags.
//  Sits between switch/register inputs and the hex_decoder display path in lab top levels.
// PARAMETERS
//  WIDTH      4   operand, quotient and remainder width in bits (>=2)
//  SIGNED_EN  1   1: is_signed input honoured; 0: is_signed ignored, always unsigned
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      reset, synchronous, active-high
//  start      in   1      request; sampled only in IDLE
//  is_signed  in   1      operands are two's complement (when SIGNED_EN=1)
//  dividend   in   WIDTH  captured on accepted start
//  divisor    in   WIDTH  captured on accepted start
//  busy       out  1      high from the cycle after an accepted start until done is asserted
//  done       out  1      one-cycle pulse; results valid from this cycle on
//  quotient   out  WIDTH  registered; held until the next done
//  remainder  out  WIDTH  registered; held until the next done
//  dbz        out  1      divide by zero flag; updated with done
//  ovf        out  1      signed overflow flag (MIN / -1); updated with done
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, dbz=0, ovf=0; internal regs cleared.
//    Reset overrides everything, including mid-operation. A partial result is discarded and done is not pulsed.
//  - States:
//    IDLE --start & divisor!=0--> CALC
//    IDLE --start & divisor==0--> FIN
//    CALC (WIDTH cycles, counter WIDTH-1..0) --count==0--> FIN
//    FIN --> IDLE
//  - Accept (IDLE & start):
//    latch |dividend| into Q and |divisor| into M. Magnitudes are used only when signed mode is active.
//    Clear A (WIDTH+1 bits). Latch sign_q = sd^sv and sign_r = sd.
//  - CALC iteration (one per cycle): {A,Q} <<= 1; T = A - {0,M}.
//    If T[WIDTH]==0: A = T, Q[0] = 1. Otherwise A is kept and Q[0] = 0.
//  - FIN: quotient <= sign_q ? -Q : Q; remainder <= sign_r ? -A[WIDTH-1:0] : A[WIDTH-1:0].
//    Same edge: done <= 1 for one cycle, busy <= 0.
//  - Latency: start sampled at edge k. done is high in the cycle after edge k+WIDTH+1 (normal path).
//    On the dbz path it is high after edge k+1.
//  - Divide by zero: quotient = all ones, remainder = dividend (raw), dbz = 1, ovf = 0. No CALC cycles.
//  - Signed overflow: dividend = 100..0 and divisor = all ones with signed mode active.
//    Result wraps: quotient = 100..0, remainder = 0, ovf = 1. Computed normally; the magnitude of MIN fits in WIDTH unsigned bits.
//  - start while busy or in FIN: ignored, never queued. Operand changes after acceptance have no effect.
//  - start high in the same cycle as done: accepted only if state is IDLE. FIN->IDLE costs one cycle.
//    Back-to-back throughput is therefore one result per WIDTH+2 cycles.
//  - Unsigned mode: all values are magnitudes. Remainder < divisor, and dividend == quotient*divisor + remainder.
//  - Signed mode: the remainder takes the sign of the dividend (or is zero); |remainder| < |divisor|.
// STRUCTURE
//  - Shared header div_defs.vh: state encodings (S_IDLE, S_CALC, S_FIN) and a clog2-based counter-width macro.
//  - One sub-module, div_step: combinational single iteration.
//    Inputs A, Q, M. Outputs next A and next Q.
//  - FSM and datapath live in this module. No separate control/datapath split.
// TESTING (WIDTH=4 unless noted)
//  - Unsigned 7/3: start 1 cycle -> busy 5 cycles, done in cycle 6; q=4'h2, r=4'h1, dbz=0, ovf=0.
//  - Divide by zero, 9/0: done in cycle 2; q=4'hF, r=4'h9, dbz=1. Next op 15/15 -> q=1, r=0, dbz cleared.
//  - Signed -7/2 (4'h9/4'h2, is_signed=1): q=4'hD (-3), r=4'hF (-1). With is_signed=0: q=4'h4, r=4'h1.
//  - Signed overflow -8/-1 (4'h8/4'hF): q=4'h8, r=4'h0, ovf=1. Same inputs with SIGNED_EN=0: q=0, r=8, ovf=0.
//  - Hold start high for 20 cycles with changing operands: exactly the first is computed.
//    done pulses once per WIDTH+2 cycles. Reset in CALC cycle 2: no done, outputs 0, next op correct.
//  - WIDTH=8 exhaustive sweep, both modes: check the identity and the sign rules for every pair.
//    Latency is always 10 cycles except divisor=0.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the iteration-counter width helper.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Bits needed to count WIDTH-1 down to 0; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M,
// and keep the difference only when it did not borrow.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] a_shift;
  logic [WIDTH+1:0] trial;

  // One guard bit above A makes the borrow visible in the MSB of the trial.
  assign a_shift = {a, q[WIDTH-1]};
  assign trial   = a_shift - {2'b00, m};

  always_comb begin
    if (trial[WIDTH+1]) begin
      a_next = a_shift[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end else begin
      a_next = trial[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider producing one quotient bit per clock, with
// optional signed (truncating) mode and divide-by-zero / overflow flags.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  localparam int               CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r;
  logic             dbz_pend, ovf_pend;

  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;

  logic             signed_mode, neg_dd, neg_dv, div_zero, accept;
  logic [WIDTH-1:0] mag_dd, mag_dv;

  assign signed_mode = SIGNED_EN && is_signed;
  assign neg_dd      = signed_mode && dividend[WIDTH-1];
  assign neg_dv      = signed_mode && divisor[WIDTH-1];
  assign mag_dd      = neg_dd ? -dividend : dividend;
  assign mag_dv      = neg_dv ? -divisor : divisor;
  assign div_zero    = (divisor == '0);

  assign busy = (state != S_IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_reg),
    .q      (q_reg),
    .m      (m_reg),
    .a_next (a_step),
    .q_next (q_step)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = div_zero ? S_FIN : S_CALC;
        end
      end
      S_CALC:  if (count == '0) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      count     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dbz_pend  <= 1'b0;
      ovf_pend  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_reg    <= '0;
            // A zero divisor skips CALC; Q then carries the raw dividend to FIN.
            q_reg    <= div_zero ? dividend : mag_dd;
            m_reg    <= mag_dv;
            count    <= CNT_INIT;
            sign_q   <= neg_dd ^ neg_dv;
            sign_r   <= neg_dd;
            dbz_pend <= div_zero;
            ovf_pend <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
          end
        end
        S_CALC: begin
          a_reg <= a_step;
          q_reg <= q_step;
          count <= count - CW'(1);
        end
        S_FIN: begin
          done <= 1'b1;
          dbz  <= dbz_pend;
          ovf  <= ovf_pend;
          if (dbz_pend) begin
            quotient  <= '1;
            remainder <= q_reg;
          end else begin
            quotient  <= sign_q ? -q_reg : q_reg;
            remainder <= sign_r ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench: a 4-bit signed-capable divider, a 4-bit unsigned-only twin
// on the same stimulus, and an 8-bit divider under random operands.
module tb_seq_restoring_divider;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic reset;

  logic         start, is_signed;
  logic [W-1:0] dividend, divisor;
  logic         busy_s, done_s, dbz_s, ovf_s;
  logic [W-1:0] q_s, r_s;
  logic         busy_u, done_u, dbz_u, ovf_u;
  logic [W-1:0] q_u, r_u;

  logic          start8, is_signed8;
  logic [W8-1:0] dividend8, divisor8;
  logic          busy8, done8, dbz8, ovf8;
  logic [W8-1:0] q8, r8;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy_s), .done(done_s),
    .quotient(q_s), .remainder(r_s), .dbz(dbz_s), .ovf(ovf_s));

  seq_restoring_divider #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy_u), .done(done_u),
    .quotient(q_u), .remainder(r_u), .dbz(dbz_u), .ovf(ovf_u));

  seq_restoring_divider #(.WIDTH(W8), .SIGNED_EN(1'b1)) dut_8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(is_signed8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .dbz(dbz8), .ovf(ovf8));

  typedef struct {
    longint q;
    longint r;
    bit     dbz;
    bit     ovf;
  } res_t;

  typedef struct {
    res_t   s;
    res_t   u;
    longint done_edge;
  } exp_t;

  exp_t   q4[$];
  exp_t   q8q[$];
  exp_t   e4, e8;
  longint cyc   = 0;
  longint free4 = 0;
  longint free8 = 0;
  int     acc4  = 0;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, which truncates toward zero and gives
  // the remainder the dividend's sign, exactly the required signed semantics.
  function automatic res_t ref_div(input int w, input bit sgn, input longint dd, input longint dv);
    res_t   res;
    longint mask = (longint'(1) << w) - 1;
    longint a    = dd;
    longint b    = dv;
    res.dbz = 1'b0;
    res.ovf = 1'b0;
    if (dv == 0) begin
      res.q   = mask;
      res.r   = dd;
      res.dbz = 1'b1;
      return res;
    end
    if (sgn) begin
      if (((dd >> (w - 1)) & 1) == 1) a = dd - (longint'(1) << w);
      if (((dv >> (w - 1)) & 1) == 1) b = dv - (longint'(1) << w);
      if (a == -(longint'(1) << (w - 1)) && b == -1) res.ovf = 1'b1;
    end
    res.q = (a / b) & mask;
    res.r = (a % b) & mask;
    return res;
  endfunction

  // Acceptance model: start is honoured only once the previous result's done
  // cycle has passed; the expected result is fixed at that moment.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q4.delete();
      q8q.delete();
      free4 = cyc + 1;
      free8 = cyc + 1;
    end else begin
      if (start && cyc >= free4) begin
        e4.s         = ref_div(W, is_signed, longint'(dividend), longint'(divisor));
        e4.u         = ref_div(W, 1'b0, longint'(dividend), longint'(divisor));
        e4.done_edge = cyc + ((divisor == '0) ? 1 : W + 1);
        free4        = e4.done_edge + 1;
        acc4++;
        q4.push_back(e4);
      end
      if (start8 && cyc >= free8) begin
        e8.s         = ref_div(W8, is_signed8, longint'(dividend8), longint'(divisor8));
        e8.u         = e8.s;
        e8.done_edge = cyc + ((divisor8 == '0) ? 1 : W8 + 1);
        free8        = e8.done_edge + 1;
        q8q.push_back(e8);
      end
    end
  end

  // Monitors: compare handshake every cycle and results whenever done is due.
  always @(negedge clk) begin
    if (!reset && cyc > 0) begin
      check("s busy", busy_s, (q4.size() > 0) && (cyc < q4[0].done_edge));
      check("u busy", busy_u, (q4.size() > 0) && (cyc < q4[0].done_edge));
      check("s done", done_s, (q4.size() > 0) && (q4[0].done_edge == cyc));
      check("u done", done_u, (q4.size() > 0) && (q4[0].done_edge == cyc));
      if (q4.size() > 0 && q4[0].done_edge == cyc) begin
        check("s quotient",  q_s,   q4[0].s.q);
        check("s remainder", r_s,   q4[0].s.r);
        check("s dbz",       dbz_s, q4[0].s.dbz);
        check("s ovf",       ovf_s, q4[0].s.ovf);
        check("u quotient",  q_u,   q4[0].u.q);
        check("u remainder", r_u,   q4[0].u.r);
        check("u dbz",       dbz_u, q4[0].u.dbz);
        check("u ovf",       ovf_u, q4[0].u.ovf);
        void'(q4.pop_front());
      end
      check("w8 busy", busy8, (q8q.size() > 0) && (cyc < q8q[0].done_edge));
      check("w8 done", done8, (q8q.size() > 0) && (q8q[0].done_edge == cyc));
      if (q8q.size() > 0 && q8q[0].done_edge == cyc) begin
        check("w8 quotient",  q8,   q8q[0].s.q);
        check("w8 remainder", r8,   q8q[0].s.r);
        check("w8 dbz",       dbz8, q8q[0].s.dbz);
        check("w8 ovf",       ovf8, q8q[0].s.ovf);
        void'(q8q.pop_front());
      end
    end
  end

  task automatic wait_idle4();
    int n = 0;
    while (q4.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("w4 drain within budget", q4.size(), 0);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (q8q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("w8 drain within budget", q8q.size(), 0);
  endtask

  task automatic op4(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg);
    @(negedge clk);
    dividend  = dd;
    divisor   = dv;
    is_signed = sg;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle4();
  endtask

  task automatic op8(input logic [W8-1:0] dd, input logic [W8-1:0] dv, input logic sg);
    @(negedge clk);
    dividend8  = dd;
    divisor8   = dv;
    is_signed8 = sg;
    start8     = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " s quotient"},  q_s,    '0);
    check({tag, " s remainder"}, r_s,    '0);
    check({tag, " s dbz"},       dbz_s,  '0);
    check({tag, " s ovf"},       ovf_s,  '0);
    check({tag, " s busy"},      busy_s, '0);
    check({tag, " s done"},      done_s, '0);
    check({tag, " u quotient"},  q_u,    '0);
    check({tag, " u remainder"}, r_u,    '0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    reset      = 1'b1;
    start      = 1'b0;
    is_signed  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    start8     = 1'b0;
    is_signed8 = 1'b0;
    dividend8  = '0;
    divisor8   = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    check("reset w8 quotient", q8, '0);
    check("reset w8 busy", busy8, '0);
    reset = 1'b0;

    op4(4'd7, 4'd3, 1'b0);
    check("7/3 q", q_s, 4'h2);
    check("7/3 r", r_s, 4'h1);
    op4(4'd9, 4'd0, 1'b0);
    check("9/0 q", q_s, 4'hF);
    check("9/0 r", r_s, 4'h9);
    check("9/0 dbz", dbz_s, 1'b1);
    op4(4'd15, 4'd15, 1'b0);
    check("15/15 q", q_s, 4'h1);
    check("15/15 r", r_s, 4'h0);
    check("15/15 dbz cleared", dbz_s, 1'b0);
    op4(4'h9, 4'h2, 1'b1);
    check("-7/2 q", q_s, 4'hD);
    check("-7/2 r", r_s, 4'hF);
    check("-7/2 unsigned-only q", q_u, 4'h4);
    check("-7/2 unsigned-only r", r_u, 4'h1);
    op4(4'h9, 4'h2, 1'b0);
    check("9/2 q", q_s, 4'h4);
    check("9/2 r", r_s, 4'h1);
    op4(4'h8, 4'hF, 1'b1);
    check("-8/-1 q", q_s, 4'h8);
    check("-8/-1 r", r_s, 4'h0);
    check("-8/-1 ovf", ovf_s, 1'b1);
    check("8/15 unsigned-only q", q_u, 4'h0);
    check("8/15 unsigned-only r", r_u, 4'h8);
    check("8/15 unsigned-only ovf", ovf_u, 1'b0);

    // Start held with changing operands: one acceptance per WIDTH+2 cycles.
    a0 = acc4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start     = 1'b1;
      dividend  = W'($urandom);
      divisor   = W'($urandom_range(1, 15));
      is_signed = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("held start accepts", acc4 - a0, 4);
    wait_idle4();

    // Reset during the second CALC cycle discards the operation.
    @(negedge clk);
    dividend  = 4'd13;
    divisor   = 4'd3;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("mid-op reset");
    reset = 1'b0;
    repeat (8) @(negedge clk);
    op4(4'd13, 4'd3, 1'b0);
    check("13/3 after reset q", q_s, 4'h4);
    check("13/3 after reset r", r_s, 4'h1);

    for (int i = 0; i < 80; i++)
      op4(W'($urandom), W'($urandom), 1'($urandom));

    for (int i = 0; i < 300; i++) begin
      logic [W8-1:0] dd, dv;
      int sel;
      dd  = W8'($urandom);
      dv  = W8'($urandom);
      sel = $urandom_range(0, 15);
      if (sel == 0) dv = '0;
      if (sel == 1) begin
        dd = 8'h80;
        dv = 8'hFF;
      end
      op8(dd, dv, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
